// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto a single memory port.
// Data has priority, with a bounded streak before a waiting fetch is forced through.
module mem_port_arbiter #(
   parameter int unsigned DATA_STREAK_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_read,
   input  logic [31:0] instr_addr,
   output logic [31:0] instr_rdata,
   output logic        instr_resp,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_mbe,
   output logic [31:0] data_rdata,
   output logic        data_resp,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [31:0] pmem_addr,
   output logic [31:0] pmem_wdata,
   output logic [3:0]  pmem_mbe,
   input  logic [31:0] pmem_rdata,
   input  logic        pmem_resp
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D
   } state_e;

   localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

   state_e      state_q, state_d;
   logic        pmem_read_q, pmem_read_d;
   logic        pmem_write_q, pmem_write_d;
   logic [31:0] pmem_addr_q, pmem_addr_d;
   logic [31:0] pmem_wdata_q, pmem_wdata_d;
   logic [3:0]  pmem_mbe_q, pmem_mbe_d;
   logic        instr_resp_q, instr_resp_d;
   logic        data_resp_q, data_resp_d;
   logic [31:0] instr_rdata_q, instr_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic [3:0]  streak_q, streak_d;

   logic        instr_live;
   logic        data_live;

   // A requester is masked during its own response cycle so a still-high request is not re-granted.
   assign instr_live = instr_read & ~instr_resp_q;
   assign data_live  = (data_read | data_write) & ~data_resp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         pmem_read_q   <= 1'b0;
         pmem_write_q  <= 1'b0;
         pmem_addr_q   <= '0;
         pmem_wdata_q  <= '0;
         pmem_mbe_q    <= '0;
         instr_resp_q  <= 1'b0;
         data_resp_q   <= 1'b0;
         instr_rdata_q <= '0;
         data_rdata_q  <= '0;
         streak_q      <= '0;
      end else begin
         state_q       <= state_d;
         pmem_read_q   <= pmem_read_d;
         pmem_write_q  <= pmem_write_d;
         pmem_addr_q   <= pmem_addr_d;
         pmem_wdata_q  <= pmem_wdata_d;
         pmem_mbe_q    <= pmem_mbe_d;
         instr_resp_q  <= instr_resp_d;
         data_resp_q   <= data_resp_d;
         instr_rdata_q <= instr_rdata_d;
         data_rdata_q  <= data_rdata_d;
         streak_q      <= streak_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pmem_read_d   = pmem_read_q;
      pmem_write_d  = pmem_write_q;
      pmem_addr_d   = pmem_addr_q;
      pmem_wdata_d  = pmem_wdata_q;
      pmem_mbe_d    = pmem_mbe_q;
      instr_resp_d  = 1'b0;
      data_resp_d   = 1'b0;
      instr_rdata_d = instr_rdata_q;
      data_rdata_d  = data_rdata_q;
      streak_d      = streak_q;

      unique case (state_q)
         IDLE: begin
            if (data_live && (!instr_live || (streak_q < STREAK_MAX))) begin
               state_d      = SERVE_D;
               pmem_addr_d  = data_addr;
               pmem_wdata_d = data_wdata;
               // Simultaneous read and write is serviced as a store.
               if (data_write) begin
                  pmem_write_d = 1'b1;
                  pmem_mbe_d   = data_mbe;
               end else begin
                  pmem_read_d  = 1'b1;
                  pmem_mbe_d   = 4'hF;
               end
               if (instr_live) begin
                  streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
               end else begin
                  streak_d = '0;
               end
            end else if (instr_live) begin
               state_d     = SERVE_I;
               pmem_read_d = 1'b1;
               pmem_addr_d = instr_addr;
               pmem_mbe_d  = 4'hF;
               streak_d    = '0;
            end else begin
               streak_d = '0;
            end
         end
         SERVE_I: begin
            if (pmem_resp) begin
               state_d       = IDLE;
               pmem_read_d   = 1'b0;
               pmem_write_d  = 1'b0;
               instr_resp_d  = 1'b1;
               instr_rdata_d = pmem_rdata;
            end
         end
         SERVE_D: begin
            if (pmem_resp) begin
               state_d      = IDLE;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               data_resp_d  = 1'b1;
               if (pmem_read_q) begin
                  data_rdata_d = pmem_rdata;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pmem_read   = pmem_read_q;
   assign pmem_write  = pmem_write_q;
   assign pmem_addr   = pmem_addr_q;
   assign pmem_wdata  = pmem_wdata_q;
   assign pmem_mbe    = pmem_mbe_q;
   assign instr_resp  = instr_resp_q;
   assign data_resp   = data_resp_q;
   assign instr_rdata = instr_rdata_q;
   assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned SMAX = 4;

   logic        clk;
   logic        rst;
   logic        instr_read;
   logic [31:0] instr_addr;
   logic [31:0] instr_rdata;
   logic        instr_resp;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_mbe;
   logic [31:0] data_rdata;
   logic        data_resp;
   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_addr;
   logic [31:0] pmem_wdata;
   logic [3:0]  pmem_mbe;
   logic [31:0] pmem_rdata;
   logic        pmem_resp;

   mem_port_arbiter #(.DATA_STREAK_MAX(SMAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_read  (instr_read),
      .instr_addr  (instr_addr),
      .instr_rdata (instr_rdata),
      .instr_resp  (instr_resp),
      .data_read   (data_read),
      .data_write  (data_write),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_mbe    (data_mbe),
      .data_rdata  (data_rdata),
      .data_resp   (data_resp),
      .pmem_read   (pmem_read),
      .pmem_write  (pmem_write),
      .pmem_addr   (pmem_addr),
      .pmem_wdata  (pmem_wdata),
      .pmem_mbe    (pmem_mbe),
      .pmem_rdata  (pmem_rdata),
      .pmem_resp   (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [3:0]  dm;
      logic        pr;
      logic [31:0] prd;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_mbe;
      logic        e_iresp;
      logic        e_dresp;
      logic [31:0] e_irdata;
      logic [31:0] e_drdata;
   } vec_t;

   vec_t vecs[16];

   // Reference model state: which requester owns the port and the transaction it carries.
   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mbe;
   } txn_t;

   int          m_owner;   // 0 none, 1 fetch, 2 data
   txn_t        m_txn;
   logic        m_iresp, m_dresp;
   logic [31:0] m_irdata, m_drdata;
   int unsigned m_streak;

   task automatic model_reset();
      m_owner  = 0;
      m_txn    = '{write: 1'b0, addr: '0, wdata: '0, mbe: '0};
      m_iresp  = 1'b0;
      m_dresp  = 1'b0;
      m_irdata = '0;
      m_drdata = '0;
      m_streak = 0;
   endtask

   // Advances the model across one clock edge using the inputs currently driven.
   task automatic model_step();
      logic ni, nd, i_live, d_live;
      ni = 1'b0;
      nd = 1'b0;
      if (m_owner != 0) begin
         if (pmem_resp) begin
            if (m_owner == 1) begin
               ni = 1'b1;
               m_irdata = pmem_rdata;
            end else begin
               nd = 1'b1;
               if (!m_txn.write) m_drdata = pmem_rdata;
            end
            m_owner = 0;
         end
      end else begin
         i_live = instr_read && !m_iresp;
         d_live = (data_read || data_write) && !m_dresp;
         if (d_live && (!i_live || m_streak < SMAX)) begin
            m_owner = 2;
            m_txn.write = data_write;
            m_txn.addr  = data_addr;
            m_txn.wdata = data_wdata;
            m_txn.mbe   = data_write ? data_mbe : 4'hF;
            m_streak    = i_live ? ((m_streak >= 15) ? 15 : m_streak + 1) : 0;
         end else if (i_live) begin
            m_owner = 1;
            m_txn.write = 1'b0;
            m_txn.addr  = instr_addr;
            m_txn.mbe   = 4'hF;
            m_streak    = 0;
         end else begin
            m_streak = 0;
         end
      end
      m_iresp = ni;
      m_dresp = nd;
   endtask

   task automatic drive_idle();
      instr_read = 1'b0; instr_addr = '0;
      data_read = 1'b0; data_write = 1'b0; data_addr = '0; data_wdata = '0; data_mbe = '0;
      pmem_resp = 1'b0; pmem_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int nd_grants;
      bit got_fetch;
      bit seen;
      bit prev_rd;
      bit bad_rd;
      int lat;
      bit prev_strobe;

      // in: ir ia dr dw da dwd dm pr prd | exp: rd wr addr wdata mbe iresp dresp irdata drdata
      vecs[0]  = '{1, 32'h60, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 32'h0,   0,           4'h0, 0, 0, 32'h0,        32'h0};
      vecs[1]  = '{1, 32'h60, 0, 0, 0, 0, 0, 0, 0,                     1, 0, 32'h60,  0,           4'hF, 0, 0, 32'h0,        32'h0};
      vecs[2]  = '{1, 32'h60, 0, 0, 0, 0, 0, 0, 0,                     1, 0, 32'h60,  0,           4'hF, 0, 0, 32'h0,        32'h0};
      vecs[3]  = '{1, 32'h60, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,          1, 0, 32'h60,  0,           4'hF, 0, 0, 32'h0,        32'h0};
      vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 32'h60,  0,           4'hF, 1, 0, 32'hDEADBEEF, 32'h0};
      vecs[5]  = '{0, 0, 0, 1, 32'h104, 32'h00AB0000, 4'b0100, 0, 0,   0, 0, 32'h60,  0,           4'hF, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[6]  = '{0, 0, 0, 1, 32'h104, 32'h00AB0000, 4'b0100, 1, 32'h12345678,
                                                                       0, 1, 32'h104, 32'h00AB0000, 4'h4, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 32'h104, 32'h00AB0000, 4'h4, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[8]  = '{1, 32'h200, 1, 0, 32'h300, 0, 0, 0, 0,              0, 0, 32'h104, 32'h00AB0000, 4'h4, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[9]  = '{1, 32'h200, 1, 0, 32'h300, 0, 0, 1, 32'hCAFE0001,   1, 0, 32'h300, 0,           4'hF, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[10] = '{1, 32'h200, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 32'h300, 0,           4'hF, 0, 1, 32'hDEADBEEF, 32'hCAFE0001};
      vecs[11] = '{1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h11112222,         1, 0, 32'h200, 0,           4'hF, 0, 0, 32'hDEADBEEF, 32'hCAFE0001};
      vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 32'h200, 0,           4'hF, 1, 0, 32'h11112222, 32'hCAFE0001};
      vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF,               0, 0, 32'h200, 0,           4'hF, 0, 0, 32'h11112222, 32'hCAFE0001};
      vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 32'h200, 0,           4'hF, 0, 0, 32'h11112222, 32'hCAFE0001};
      vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 32'h200, 0,           4'hF, 0, 0, 32'h11112222, 32'hCAFE0001};

      do_reset();

      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         chk($sformatf("v%0d.pmem_read", i),   64'(pmem_read),   64'(vecs[i].e_rd));
         chk($sformatf("v%0d.pmem_write", i),  64'(pmem_write),  64'(vecs[i].e_wr));
         chk($sformatf("v%0d.pmem_addr", i),   64'(pmem_addr),   64'(vecs[i].e_addr));
         chk($sformatf("v%0d.pmem_wdata", i),  64'(pmem_wdata),  64'(vecs[i].e_wdata));
         chk($sformatf("v%0d.pmem_mbe", i),    64'(pmem_mbe),    64'(vecs[i].e_mbe));
         chk($sformatf("v%0d.instr_resp", i),  64'(instr_resp),  64'(vecs[i].e_iresp));
         chk($sformatf("v%0d.data_resp", i),   64'(data_resp),   64'(vecs[i].e_dresp));
         chk($sformatf("v%0d.instr_rdata", i), 64'(instr_rdata), 64'(vecs[i].e_irdata));
         chk($sformatf("v%0d.data_rdata", i),  64'(data_rdata),  64'(vecs[i].e_drdata));
         instr_read = vecs[i].ir;  instr_addr = vecs[i].ia;
         data_read  = vecs[i].dr;  data_write = vecs[i].dw;  data_addr = vecs[i].da;
         data_wdata = vecs[i].dwd; data_mbe   = vecs[i].dm;
         pmem_resp  = vecs[i].pr;  pmem_rdata = vecs[i].prd;
      end

      // Read and write together: must be serviced as a store only.
      data_read = 1'b1; data_write = 1'b1; data_addr = 32'h8; data_wdata = 32'h55; data_mbe = 4'h3;
      seen = 0; bad_rd = 0;
      for (int c = 0; c < 6 && !seen; c++) begin
         @(posedge clk); #1;
         if (pmem_read) bad_rd = 1;
         if (pmem_write) seen = 1;
      end
      chk("rw.write_granted", 64'(seen), 64'(1));
      chk("rw.addr", 64'(pmem_addr), 64'(32'h8));
      chk("rw.mbe", 64'(pmem_mbe), 64'(4'h3));
      pmem_resp = 1'b1; pmem_rdata = 32'h77777777;
      @(posedge clk); #1;
      if (pmem_read) bad_rd = 1;
      pmem_resp = 1'b0; data_read = 1'b0; data_write = 1'b0;
      chk("rw.data_resp", 64'(data_resp), 64'(1));
      chk("rw.data_rdata_kept", 64'(data_rdata), 64'(32'hCAFE0001));
      repeat (2) begin
         @(posedge clk); #1;
         if (pmem_read) bad_rd = 1;
      end
      chk("rw.no_read", 64'(bad_rd), 64'(0));

      // Asynchronous reset in the middle of a fetch, then re-arbitration of the held request.
      instr_read = 1'b1; instr_addr = 32'h700;
      seen = 0;
      for (int c = 0; c < 6 && !seen; c++) begin
         @(posedge clk); #1;
         if (pmem_read) seen = 1;
      end
      chk("rst.fetch_started", 64'(seen), 64'(1));
      #2 rst = 1'b0;
      #1;
      chk("rst.pmem_read_async", 64'(pmem_read), 64'(0));
      chk("rst.instr_resp", 64'(instr_resp), 64'(0));
      chk("rst.pmem_addr", 64'(pmem_addr), 64'(0));
      chk("rst.pmem_mbe", 64'(pmem_mbe), 64'(0));
      @(posedge clk); #1;
      chk("rst.held_in_reset", 64'(pmem_read), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst.regrant_read", 64'(pmem_read), 64'(1));
      chk("rst.regrant_addr", 64'(pmem_addr), 64'(32'h700));
      pmem_resp = 1'b1; pmem_rdata = 32'hA5A5A5A5;
      @(posedge clk); #1;
      pmem_resp = 1'b0; instr_read = 1'b0;
      chk("rst.instr_resp", 64'(instr_resp), 64'(1));
      chk("rst.instr_rdata", 64'(instr_rdata), 64'(32'hA5A5A5A5));

      // Fetch held against continuously re-issued loads: fetch must win within the streak bound.
      @(posedge clk); #1;
      instr_read = 1'b1; instr_addr = 32'h400;
      data_read = 1'b1; data_addr = 32'h500;
      nd_grants = 0; got_fetch = 0; prev_rd = 0;
      for (int c = 0; c < 60 && !got_fetch; c++) begin
         @(posedge clk); #1;
         pmem_resp = 1'b0;
         if (pmem_read && !prev_rd) begin
            if (pmem_addr == 32'h400) got_fetch = 1;
            else nd_grants++;
         end
         if (pmem_read) begin
            pmem_resp = 1'b1; pmem_rdata = $urandom;
         end
         prev_rd = pmem_read;
      end
      data_read = 1'b0;
      chk("starve.fetch_granted", 64'(got_fetch), 64'(1));
      chk("starve.data_before_fetch_in_bound",
          64'((nd_grants >= 1) && (nd_grants <= int'(SMAX))), 64'(1));
      seen = 0;
      for (int c = 0; c < 6 && !seen; c++) begin
         @(posedge clk); #1;
         pmem_resp = 1'b0;
         if (instr_resp) seen = 1;
      end
      instr_read = 1'b0;
      chk("starve.fetch_done", 64'(seen), 64'(1));

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      lat = 0; prev_strobe = 0;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         chk($sformatf("rnd%0d.pmem_read", c),   64'(pmem_read),   64'(m_owner != 0 && !m_txn.write));
         chk($sformatf("rnd%0d.pmem_write", c),  64'(pmem_write),  64'(m_owner != 0 && m_txn.write));
         if (m_owner != 0) begin
            chk($sformatf("rnd%0d.pmem_addr", c), 64'(pmem_addr), 64'(m_txn.addr));
            chk($sformatf("rnd%0d.pmem_mbe", c),  64'(pmem_mbe),  64'(m_txn.mbe));
         end
         if (m_owner == 2 && m_txn.write)
            chk($sformatf("rnd%0d.pmem_wdata", c), 64'(pmem_wdata), 64'(m_txn.wdata));
         chk($sformatf("rnd%0d.instr_resp", c),  64'(instr_resp),  64'(m_iresp));
         chk($sformatf("rnd%0d.data_resp", c),   64'(data_resp),   64'(m_dresp));
         chk($sformatf("rnd%0d.instr_rdata", c), 64'(instr_rdata), 64'(m_irdata));
         chk($sformatf("rnd%0d.data_rdata", c),  64'(data_rdata),  64'(m_drdata));

         if (!instr_read || instr_resp) begin
            if ($urandom_range(0, 2) == 0) begin
               instr_read = 1'b1; instr_addr = $urandom;
            end else begin
               instr_read = 1'b0;
            end
         end
         if (!(data_read || data_write) || data_resp) begin
            if ($urandom_range(0, 1) == 0) begin
               int op;
               op = int'($urandom_range(0, 2));
               data_read  = (op != 1);
               data_write = (op != 0);
               data_addr  = $urandom;
               data_wdata = $urandom;
               data_mbe   = 4'($urandom_range(0, 15));
            end else begin
               data_read = 1'b0; data_write = 1'b0;
            end
         end
         pmem_resp = 1'b0;
         if (pmem_read || pmem_write) begin
            if (!prev_strobe) lat = int'($urandom_range(0, 3));
            if (lat == 0) begin
               pmem_resp = 1'b1; pmem_rdata = $urandom;
            end else begin
               lat--;
            end
         end else if ($urandom_range(0, 9) == 0) begin
            pmem_resp = 1'b1; pmem_rdata = $urandom;
         end
         prev_strobe = pmem_read || pmem_write;
         model_step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
